// File: rtl/lcd_win_ctrl.sv
// lcd_win_ctrl: loads a 2^WL2 x 2^HL2 image from IROM into an internal buffer,
// runs 2x2 window commands at a movable point, and streams the buffer to IRAM.
// Optional feature macro: LCD_WRAP_EN (point shifts wrap instead of saturating).
module lcd_win_ctrl #(
  parameter int unsigned DW  = 8,
  parameter int unsigned WL2 = 3,
  parameter int unsigned HL2 = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           cmd,
  input  logic                 cmd_valid,
  input  logic [DW-1:0]        IROM_Q,
  output logic                 IROM_rd,
  output logic [WL2+HL2-1:0]   IROM_A,
  output logic                 IRAM_valid,
  output logic [DW-1:0]        IRAM_D,
  output logic [WL2+HL2-1:0]   IRAM_A,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned AW = WL2 + HL2;
  localparam int unsigned N  = 1 << AW;
  localparam logic [AW-1:0]  A_LAST = '1;
  localparam logic [WL2-1:0] X_MAX  = '1;
  localparam logic [HL2-1:0] Y_MAX  = '1;
  localparam logic [WL2-1:0] X_MID  = WL2'(1 << (WL2 - 1));
  localparam logic [HL2-1:0] Y_MID  = HL2'(1 << (HL2 - 1));
`ifdef LCD_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [2:0] {S_LOAD, S_CMD, S_OP, S_WRITE, S_FIN} state_t;

  state_t           r_state;
  logic [DW-1:0]    r_buf [N];
  logic [3:0]       r_cmd;
  logic [WL2-1:0]   r_px;
  logic [HL2-1:0]   r_py;
  logic             r_irom_rd;
  logic [AW-1:0]    r_irom_a;
  logic             r_iram_valid;
  logic [AW-1:0]    r_iram_a;
  logic [DW-1:0]    r_iram_d;
  logic             r_busy;
  logic             r_done;

  logic [AW-1:0]    w_a1, w_a2, w_a3, w_a4;
  logic [DW-1:0]    w_p1, w_p2, w_p3, w_p4;
  logic [DW-1:0]    w_n1, w_n2, w_n3, w_n4;
  logic [DW-1:0]    w_mx12, w_mx34, w_max, w_mn12, w_mn34, w_min;
  logic [DW+1:0]    w_sum;
  logic [DW-1:0]    w_avg;
  logic             w_we;
  logic [WL2-1:0]   w_px_n;
  logic [HL2-1:0]   w_py_n;

  assign IROM_rd    = r_irom_rd;
  assign IROM_A     = r_irom_a;
  assign IRAM_valid = r_iram_valid;
  assign IRAM_A     = r_iram_a;
  assign IRAM_D     = r_iram_d;
  assign busy       = r_busy;
  assign done       = r_done;

  // Window addresses: y*W + x is a plain concatenation for power-of-two widths
  assign w_a1 = {r_py - HL2'(1), r_px - WL2'(1)};
  assign w_a2 = {r_py - HL2'(1), r_px};
  assign w_a3 = {r_py, r_px - WL2'(1)};
  assign w_a4 = {r_py, r_px};
  assign w_p1 = r_buf[w_a1];
  assign w_p2 = r_buf[w_a2];
  assign w_p3 = r_buf[w_a3];
  assign w_p4 = r_buf[w_a4];

  // Window reductions; the sum carries two extra bits so it never overflows
  assign w_mx12 = (w_p1 > w_p2) ? w_p1 : w_p2;
  assign w_mx34 = (w_p3 > w_p4) ? w_p3 : w_p4;
  assign w_max  = (w_mx12 > w_mx34) ? w_mx12 : w_mx34;
  assign w_mn12 = (w_p1 < w_p2) ? w_p1 : w_p2;
  assign w_mn34 = (w_p3 < w_p4) ? w_p3 : w_p4;
  assign w_min  = (w_mn12 < w_mn34) ? w_mn12 : w_mn34;
  assign w_sum  = (DW+2)'(w_p1) + (DW+2)'(w_p2) + (DW+2)'(w_p3) + (DW+2)'(w_p4);
  assign w_avg  = w_sum[DW+1:2];

  // New window pixels and new point for the latched command
  always_comb begin
    w_n1   = w_p1;
    w_n2   = w_p2;
    w_n3   = w_p3;
    w_n4   = w_p4;
    w_we   = 1'b0;
    w_px_n = r_px;
    w_py_n = r_py;
    case (r_cmd)
      4'd1:  w_py_n = (r_py == HL2'(1)) ? (WRAP ? Y_MAX : r_py) : r_py - HL2'(1);
      4'd2:  w_py_n = (r_py == Y_MAX) ? (WRAP ? HL2'(1) : r_py) : r_py + HL2'(1);
      4'd3:  w_px_n = (r_px == WL2'(1)) ? (WRAP ? X_MAX : r_px) : r_px - WL2'(1);
      4'd4:  w_px_n = (r_px == X_MAX) ? (WRAP ? WL2'(1) : r_px) : r_px + WL2'(1);
      4'd5:  begin w_we = 1'b1; w_n1 = w_max; w_n2 = w_max; w_n3 = w_max; w_n4 = w_max; end
      4'd6:  begin w_we = 1'b1; w_n1 = w_min; w_n2 = w_min; w_n3 = w_min; w_n4 = w_min; end
      4'd7:  begin w_we = 1'b1; w_n1 = w_avg; w_n2 = w_avg; w_n3 = w_avg; w_n4 = w_avg; end
      4'd8:  begin w_we = 1'b1; w_n1 = w_p2; w_n2 = w_p4; w_n3 = w_p1; w_n4 = w_p3; end
      4'd9:  begin w_we = 1'b1; w_n1 = w_p3; w_n2 = w_p1; w_n3 = w_p4; w_n4 = w_p2; end
      4'd10: begin w_we = 1'b1; w_n1 = w_p3; w_n2 = w_p4; w_n3 = w_p1; w_n4 = w_p2; end
      4'd11: begin w_we = 1'b1; w_n1 = w_p2; w_n2 = w_p1; w_n3 = w_p4; w_n4 = w_p3; end
      4'd12: begin w_px_n = X_MID; w_py_n = Y_MID; end
      4'd13: begin w_we = 1'b1; w_n1 = ~w_p1; w_n2 = ~w_p2; w_n3 = ~w_p3; w_n4 = ~w_p4; end
      default: ;
    endcase
  end

  // Image buffer: filled during load, updated by window operations
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      r_buf[r_irom_a] <= IROM_Q;
    end else if (r_state == S_OP && w_we) begin
      r_buf[w_a1] <= w_n1;
      r_buf[w_a2] <= w_n2;
      r_buf[w_a3] <= w_n3;
      r_buf[w_a4] <= w_n4;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_cmd        <= 4'd0;
      r_px         <= X_MID;
      r_py         <= Y_MID;
      r_irom_rd    <= 1'b1;
      r_irom_a     <= '0;
      r_iram_valid <= 1'b0;
      r_iram_a     <= '0;
      r_iram_d     <= '0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_irom_a <= r_irom_a + AW'(1);
          if (r_irom_a == A_LAST) begin
            r_irom_rd <= 1'b0;
            r_irom_a  <= '0;
            r_busy    <= 1'b0;
            r_state   <= S_CMD;
          end
        end
        S_CMD: begin
          r_done <= 1'b0;
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (cmd_valid) begin
            r_cmd  <= cmd;
            r_busy <= 1'b1;
            if (cmd == 4'd0) begin
              r_state      <= S_WRITE;
              r_iram_valid <= 1'b1;
              r_iram_a     <= '0;
              r_iram_d     <= r_buf[0];
            end else if (cmd == 4'd14) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else if (cmd != 4'd15) begin
              r_state <= S_OP;
            end
          end
        end
        S_OP: begin
          r_px    <= w_px_n;
          r_py    <= w_py_n;
          r_busy  <= 1'b0;
          r_state <= S_CMD;
        end
        S_WRITE: begin
          if (r_iram_a == A_LAST) begin
            r_iram_valid <= 1'b0;
            r_iram_a     <= '0;
            r_iram_d     <= '0;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_CMD;
          end else begin
            r_iram_a <= r_iram_a + AW'(1);
            r_iram_d <= r_buf[r_iram_a + AW'(1)];
          end
        end
        S_FIN: begin
          r_busy <= 1'b1;
          r_done <= 1'b1;
        end
        default: r_state <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Directed self-checking bench for lcd_win_ctrl (8x8 image, 8-bit pixels).
module tb_lcd_win_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [7:0] IROM_Q;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic       IRAM_valid;
  logic [7:0] IRAM_D;
  logic [5:0] IRAM_A;
  logic       busy;
  logic       done;

  logic [7:0] rom [64];
  logic [7:0] img [64];
  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int cyc;
  int snap;

`ifdef LCD_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  lcd_win_ctrl dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(IROM_Q), .IROM_rd(IROM_rd), .IROM_A(IROM_A),
    .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D), .IRAM_A(IRAM_A),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign IROM_Q = rom[IROM_A];

  always @(posedge clk) if (IRAM_valid === 1'b1) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ramp();
    for (int k = 0; k < 64; k++) rom[k] = 8'(k);
  endtask

  task automatic set_win(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    ramp();
    rom[27] = a; rom[28] = b; rom[35] = c; rom[36] = d;
  endtask

  task automatic wait_ready();
    int c = 0;
    while (busy !== 1'b0 && c < 300) begin @(negedge clk); c++; end
    chk("ready", 32'(busy), 0);
  endtask

  task automatic reload();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ready();
  endtask

  task automatic issue(input logic [3:0] c);
    wait_ready();
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input bit ramp_chk);
    int bad = 0;
    issue(4'd0);
    for (int k = 0; k < 64; k++) begin
      if (IRAM_valid !== 1'b1 || IRAM_A !== 6'(k)) bad++;
      if (ramp_chk && IRAM_D !== 8'(k)) bad++;
      img[k] = IRAM_D;
      @(negedge clk);
    end
    chk("write_seq", 32'(bad), 0);
    chk("write_end_valid", 32'(IRAM_valid), 0);
    chk("write_end_addr", 32'(IRAM_A), 0);
    chk("write_done", 32'(done), 1);
    chk("write_busy", 32'(busy), 0);
    @(negedge clk);
    chk("done_pulse_clear", 32'(done), 0);
  endtask

  task automatic chk_win(input string tag, input int a1, input int a2, input int a3, input int a4,
                         input int e1, input int e2, input int e3, input int e4);
    chk({tag, "_p1"}, 32'(img[a1]), 32'(e1));
    chk({tag, "_p2"}, 32'(img[a2]), 32'(e2));
    chk({tag, "_p3"}, 32'(img[a3]), 32'(e3));
    chk({tag, "_p4"}, 32'(img[a4]), 32'(e4));
  endtask

  initial begin
    reset = 1'b1; cmd = 4'd0; cmd_valid = 1'b0;
    ramp();
    repeat (3) @(negedge clk);
    chk("rst_irom_rd", 32'(IROM_rd), 1);
    chk("rst_irom_a", 32'(IROM_A), 0);
    chk("rst_iram_valid", 32'(IRAM_valid), 0);
    chk("rst_iram_a", 32'(IRAM_A), 0);
    chk("rst_iram_d", 32'(IRAM_D), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_done", 32'(done), 0);

    // Load latency and first ramp write
    reset = 1'b0;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("load_cycles", 32'(cyc), 64);
    chk("load_irom_rd", 32'(IROM_rd), 0);
    chk("load_irom_a", 32'(IROM_A), 0);
    do_write(1'b1);
    do_write(1'b1);

    // Max at centre point, then Min after reload
    issue(4'd5); do_write(1'b0);
    chk_win("max", 27, 28, 35, 36, 36, 36, 36, 36);
    chk("max_untouched", 32'(img[26]), 26);
    reload(); issue(4'd6); do_write(1'b0);
    chk_win("min", 27, 28, 35, 36, 27, 27, 27, 27);

    // Average, including the no-overflow corner
    set_win(8'd10, 8'd11, 8'd12, 8'd14); reload(); issue(4'd7); do_write(1'b0);
    chk_win("avg", 27, 28, 35, 36, 11, 11, 11, 11);
    set_win(8'd255, 8'd255, 8'd255, 8'd254); reload(); issue(4'd7); do_write(1'b0);
    chk_win("avg_big", 27, 28, 35, 36, 254, 254, 254, 254);

    // Rotations, mirrors and invert on A,B,C,D = 1,2,3,4
    set_win(8'd1, 8'd2, 8'd3, 8'd4); reload(); issue(4'd9); do_write(1'b0);
    chk_win("cw", 27, 28, 35, 36, 3, 1, 4, 2);
    reload(); issue(4'd8); do_write(1'b0);
    chk_win("ccw", 27, 28, 35, 36, 2, 4, 1, 3);
    reload(); issue(4'd10); do_write(1'b0);
    chk_win("mirx", 27, 28, 35, 36, 3, 4, 1, 2);
    reload(); issue(4'd11); do_write(1'b0);
    chk_win("miry", 27, 28, 35, 36, 2, 1, 4, 3);
    set_win(8'h0F, 8'h00, 8'hFF, 8'h5A); reload(); issue(4'd13); do_write(1'b0);
    chk_win("inv", 27, 28, 35, 36, 8'hF0, 8'hFF, 8'h00, 8'hA5);

    // Eight lefts from px=4, then Max
    ramp(); reload();
    repeat (8) issue(4'd3);
    issue(4'd5); do_write(1'b0);
    if (WRAP) chk_win("left8", 26, 27, 34, 35, 35, 35, 35, 35);
    else      chk_win("left8", 24, 25, 32, 33, 33, 33, 33, 33);

    // Four lefts + Min; centre, four ups + Max; centre, four downs/rights + Min
    reload();
    repeat (4) issue(4'd3);
    issue(4'd6);
    issue(4'd12);
    repeat (4) issue(4'd1);
    issue(4'd5);
    issue(4'd12);
    repeat (4) issue(4'd2);
    repeat (4) issue(4'd4);
    issue(4'd6);
    do_write(1'b0);
    if (WRAP) begin
      chk_win("left4", 30, 31, 38, 39, 30, 30, 30, 30);
      chk_win("up4", 51, 52, 59, 60, 60, 60, 60, 60);
      chk_win("dnrt4", 0, 1, 8, 9, 0, 0, 0, 0);
    end else begin
      chk_win("left4", 24, 25, 32, 33, 24, 24, 24, 24);
      chk_win("up4", 3, 4, 11, 12, 12, 12, 12, 12);
      chk_win("dnrt4", 54, 55, 62, 63, 54, 54, 54, 54);
    end

    // Command while busy is dropped; NOP holds busy for one cycle
    reload();
    issue(4'd5);
    cmd = 4'd13; cmd_valid = 1'b1;
    chk("op_busy", 32'(busy), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("op_busy_clear", 32'(busy), 0);
    issue(4'd15);
    chk("nop_busy", 32'(busy), 1);
    @(negedge clk);
    chk("nop_busy_clear", 32'(busy), 0);
    do_write(1'b0);
    chk_win("ignored", 27, 28, 35, 36, 36, 36, 36, 36);

    // Reset in the middle of a write
    issue(4'd0);
    repeat (20) @(negedge clk);
    chk("midwr_addr", 32'(IRAM_A), 20);
    chk("midwr_valid", 32'(IRAM_valid), 1);
    reset = 1'b1;
    #1;
    chk("rstwr_valid", 32'(IRAM_valid), 0);
    chk("rstwr_addr", 32'(IRAM_A), 0);
    chk("rstwr_busy", 32'(busy), 1);
    chk("rstwr_irom_rd", 32'(IROM_rd), 1);
    @(negedge clk);
    reset = 1'b0;
    snap = wr_cnt;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("reload_cycles", 32'(cyc), 64);
    chk("no_writes_after_rst", 32'(wr_cnt), 32'(snap));
    do_write(1'b1);

    // Finish: done held, later commands ignored
    issue(4'd14);
    chk("fin_done", 32'(done), 1);
    chk("fin_busy", 32'(busy), 1);
    snap = wr_cnt;
    repeat (5) @(negedge clk);
    cmd = 4'd0; cmd_valid = 1'b1;
    repeat (10) @(negedge clk);
    cmd_valid = 1'b0;
    chk("fin_done_hold", 32'(done), 1);
    chk("fin_busy_hold", 32'(busy), 1);
    chk("fin_no_write", 32'(wr_cnt), 32'(snap));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
